// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences reset-then-run of a controlled core, with free-run or
// single-step enables, halt/abort handling and a bounded, sticky-timeout cycle counter.
module core_run_ctrl #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 9999
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_mode_i,
  input  logic             step_i,
  input  logic             halt_i,
  input  logic             abort_i,
  output logic             core_rst_o,
  output logic             core_en_o,
  output logic             running_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_STEP,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [RC_W-1:0]   rst_cnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              limit_hit;
  logic              step_mode_q;
  logic              core_rst_q;
  logic              core_en_q;
  logic              running_q;
  logic              done_q;
  logic              timeout_q;

  // Count the current cycle if the core is enabled in it; flag reaching the limit.
  always_comb begin
    cnt_d     = cnt_q;
    limit_hit = 1'b0;
    if (core_en_q) begin
      cnt_d     = cnt_q + CNT_W'(1);
      limit_hit = (cnt_d == CNT_W'(MAX_CYCLES));
    end
  end

  // Sequencer state and all registered outputs; abort beats halt, halt beats limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      step_mode_q <= 1'b0;
      core_rst_q  <= 1'b1;
      core_en_q   <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q     <= S_RESET;
            rst_cnt_q   <= RC_W'(RST_CYCLES - 1);
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            step_mode_q <= step_mode_i;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
            running_q   <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        S_RESET: begin
          if (abort_i) begin
            state_q    <= S_IDLE;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            running_q  <= 1'b0;
          end else if (rst_cnt_q == '0) begin
            state_q    <= step_mode_q ? S_STEP : S_RUN;
            core_rst_q <= 1'b0;
            core_en_q  <= ~step_mode_q;
          end else begin
            rst_cnt_q <= rst_cnt_q - RC_W'(1);
          end
        end
        S_RUN, S_STEP: begin
          if (abort_i) begin
            state_q    <= S_IDLE;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            running_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            if (halt_i || limit_hit) begin
              state_q   <= S_DONE;
              core_en_q <= 1'b0;
              running_q <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= ~halt_i;
            end else if (state_q == S_STEP) begin
              core_en_q <= step_i;
            end else begin
              core_en_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          core_rst_q <= 1'b1;
          core_en_q  <= 1'b0;
          running_q  <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst_o  = core_rst_q;
  assign core_en_o   = core_en_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Testbench for core_run_ctrl: randomized runs checked against run-level predictions.
module tb_core_run_ctrl;

  localparam int unsigned RST_CYC = 2;
  localparam int unsigned CW      = 16;
  localparam int unsigned MAXC    = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, step_mode, step, halt, abort;
  logic core_rst, core_en, running, done, timeout;
  logic [CW-1:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  core_run_ctrl #(.RST_CYCLES(RST_CYC), .CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .step_mode_i(step_mode),
    .step_i(step), .halt_i(halt), .abort_i(abort),
    .core_rst_o(core_rst), .core_en_o(core_en), .running_o(running),
    .done_o(done), .timeout_o(timeout), .cycle_cnt_o(cycle_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic sm);
    start = 1'b1;
    step_mode = sm;
    tick();
    start = 1'b0;
    step_mode = ~sm;
  endtask

  // Wait through RESET into STEP; returns number of cycles core_rst was seen while running.
  task automatic wait_step(output int rc);
    rc = 0;
    for (int n = 0; n < 20; n++) begin
      if (running && !core_rst) break;
      if (running && core_rst) rc++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({core_rst, core_en, running, done, timeout} !== 5'b10000 || cycle_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: rst/en/run/done/to=%b cnt=%0d, required 10000 cnt=0",
               {core_rst, core_en, running, done, timeout}, cycle_cnt);
    end
    abort = 1'b1; halt = 1'b1; step = 1'b1;
    tick();
    abort = 1'b0; halt = 1'b0; step = 1'b0;
    checks++;
    if ({core_rst, core_en, running, done} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_ignores_inputs: rst/en/run/done=%b, required 1000",
               {core_rst, core_en, running, done});
    end
  endtask

  // Free run with halt raised during enabled cycle h (0 = never); a stray start mid-run is ignored.
  task automatic test_free_run(input int h);
    int rc, ec, n, exp_n;
    bit exp_to;
    rc = 0; ec = 0;
    exp_to = (h == 0) || (h > int'(MAXC));
    exp_n  = exp_to ? int'(MAXC) : h;
    do_start(1'b0);
    for (n = 0; n < 200 && !done; n++) begin
      halt = 1'b0;
      start = 1'b0;
      if (running && core_rst) rc++;
      if (core_en) begin
        ec++;
        if (ec == h) halt = 1'b1;
        if (ec == 3) start = 1'b1;
      end
      tick();
    end
    halt = 1'b0; start = 1'b0;
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL free_run_done_timeout: done never rose within 200 cycles (h=%0d)", h);
    end
    checks++;
    if (rc != int'(RST_CYC) || ec != exp_n) begin
      errors++;
      $display("FAIL free_run_counts: h=%0d core_rst cycles=%0d en cycles=%0d, required %0d and %0d",
               h, rc, ec, RST_CYC, exp_n);
    end
    checks++;
    if (cycle_cnt !== CW'(exp_n) || timeout !== exp_to) begin
      errors++;
      $display("FAIL free_run_result: h=%0d cnt=%0d timeout=%b, required cnt=%0d timeout=%b",
               h, cycle_cnt, timeout, exp_n, exp_to);
    end
    tick(); tick();
    checks++;
    if ({core_rst, core_en, running, done} !== 4'b0001 || cycle_cnt !== CW'(exp_n) || timeout !== exp_to) begin
      errors++;
      $display("FAIL done_hold: rst/en/run/done=%b cnt=%0d to=%b, required 0001 cnt=%0d to=%b",
               {core_rst, core_en, running, done}, cycle_cnt, timeout, exp_n, exp_to);
    end
  endtask

  // Step mode: each cycle step is sampled high gives one core_en cycle on the next cycle.
  task automatic test_step(input bit fixed);
    logic [31:0] pat;
    int len, rc, ones;
    logic prev;
    if (fixed) begin
      pat = 32'h0000_0111;
      len = 12;
    end else begin
      pat = $urandom;
      len = 16;
    end
    ones = 0;
    for (int i = 0; i < len; i++) ones += int'(pat[i]);
    do_start(1'b1);
    wait_step(rc);
    checks++;
    if (rc != int'(RST_CYC) || core_en !== 1'b0) begin
      errors++;
      $display("FAIL step_entry: core_rst cycles=%0d en=%b, required %0d and 0", rc, core_en, RST_CYC);
    end
    for (int i = 0; i <= len + 2; i++) begin
      prev = (i > 0 && i <= len) ? pat[i-1] : 1'b0;
      checks++;
      if (core_en !== prev) begin
        errors++;
        $display("FAIL step_enable: cycle %0d core_en=%b, required %b", i, core_en, prev);
      end
      step = (i < len) ? pat[i] : 1'b0;
      tick();
    end
    checks++;
    if (cycle_cnt !== CW'(ones) || running !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL step_count: cnt=%0d running=%b done=%b, required cnt=%0d running=1 done=0",
               cycle_cnt, running, done, ones);
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || core_en !== 1'b0 || cycle_cnt !== CW'(ones)) begin
      errors++;
      $display("FAIL step_halt: done=%b to=%b en=%b cnt=%0d, required 1 0 0 cnt=%0d",
               done, timeout, core_en, cycle_cnt, ones);
    end
  endtask

  // Step held high continuously runs into the cycle limit.
  task automatic test_step_limit();
    int rc, ec, n;
    ec = 0;
    do_start(1'b1);
    wait_step(rc);
    for (n = 0; n < 80 && !done; n++) begin
      if (core_en) ec++;
      step = 1'b1;
      tick();
    end
    step = 1'b0;
    checks++;
    if (done !== 1'b1 || ec != int'(MAXC) || cycle_cnt !== CW'(MAXC) || timeout !== 1'b1) begin
      errors++;
      $display("FAIL step_limit: done=%b en cycles=%0d cnt=%0d to=%b, required 1 %0d %0d 1",
               done, ec, cycle_cnt, timeout, MAXC, MAXC);
    end
  endtask

  task automatic test_abort();
    int rc;
    // abort is ignored in DONE
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_done: done=%b running=%b, required 1 0", done, running);
    end
    // abort during RESET
    do_start(1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({core_rst, core_en, running, done} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_in_reset: rst/en/run/done=%b, required 1000", {core_rst, core_en, running, done});
    end
    // abort together with halt during RUN
    do_start(1'b0);
    for (int n = 0; n < 20 && !core_en; n++) tick();
    repeat ($urandom_range(0, 8)) tick();
    abort = 1'b1; halt = 1'b1;
    tick();
    abort = 1'b0; halt = 1'b0;
    checks++;
    if ({core_rst, core_en, running, done} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_halt_in_run: rst/en/run/done=%b, required 1000", {core_rst, core_en, running, done});
    end
    // abort with step in STEP
    do_start(1'b1);
    wait_step(rc);
    step = 1'b1; abort = 1'b1;
    tick();
    step = 1'b0; abort = 1'b0;
    tick();
    checks++;
    if ({core_rst, core_en, running, done} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_in_step: rst/en/run/done=%b, required 1000", {core_rst, core_en, running, done});
    end
    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({core_rst, running, done} !== 3'b110 || cycle_cnt !== '0) begin
      errors++;
      $display("FAIL start_beats_abort: rst/run/done=%b cnt=%0d, required 110 cnt=0",
               {core_rst, running, done}, cycle_cnt);
    end
  endtask

  task automatic test_rst_midrun();
    int n;
    do_start(1'b0);
    for (n = 0; n < 40; n++) begin
      if (core_en && cycle_cnt == CW'(7)) break;
      tick();
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL rst_midrun_reach: cycle_cnt never reached 7 in RUN");
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({core_rst, core_en, running, done, timeout} !== 5'b10000 || cycle_cnt !== '0) begin
      errors++;
      $display("FAIL rst_midrun: rst/en/run/done/to=%b cnt=%0d, required 10000 cnt=0",
               {core_rst, core_en, running, done, timeout}, cycle_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_free_run(10);
    test_free_run(0);
    test_free_run(int'(MAXC));
    for (int k = 0; k < 6; k++) test_free_run(int'($urandom_range(0, MAXC + 3)));
    test_step(1'b1);
    for (int k = 0; k < 4; k++) test_step(1'b0);
    test_step_limit();
    test_abort();
    test_rst_midrun();
    test_free_run(int'($urandom_range(1, MAXC - 1)));
    test_free_run(0);
    test_rst_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: cycles core_rst is held high after start (>=1).
REQ-002 Parameter CNT_W, default 16: width of cycle counter.
REQ-003 Parameter MAX_CYCLES, default 9999: run-cycle limit before timeout (1..2^CNT_W-1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  pulse; begins a reset-then-run sequence from IDLE or DONE.
REQ-007 step_mode  input  1  1 = single-step, 0 = free-run; sampled on the start cycle.
REQ-008 step  input  1  pulse; grants one core_en cycle in step mode.
REQ-009 halt_in  input  1  core halt indication; ends the run.
REQ-010 abort  input  1  pulse; ends any active sequence.
REQ-011 core_rst  output  1  reset to the core under control.
REQ-012 core_en  output  1  clock enable to the core.
REQ-013 running  output  1  high in RESET, RUN or STEP states.
REQ-014 done  output  1  high in DONE state.
REQ-015 timeout  output  1  sticky; set when the run ended by the cycle limit.
REQ-016 cycle_cnt  output  CNT_W  number of core_en cycles in the current run.

Function
REQ-017 States: IDLE, RESET, RUN, STEP, DONE; registered, one transition per clock edge max.
REQ-018 IDLE: core_rst=1, core_en=0; start -> RESET, clears cycle_cnt and timeout, latches step_mode.
REQ-019 RESET: core_rst=1, core_en=0 for exactly RST_CYCLES cycles, then -> RUN (free) or STEP (step mode).
REQ-020 RUN: core_rst=0, core_en=1 every cycle; cycle_cnt increments by 1 per cycle in RUN.
REQ-021 STEP: core_rst=0; core_en=1 only in the cycle after a step pulse is sampled, one cycle per pulse; cycle_cnt increments on each enabled cycle; step held high for several cycles yields one enable per cycle it is high.
REQ-022 halt_in sampled high in RUN/STEP -> DONE next edge; no further core_en.
REQ-023 When cycle_cnt reaches MAX_CYCLES in RUN/STEP -> DONE, timeout=1; cycle_cnt never exceeds MAX_CYCLES and never wraps.
REQ-024 halt_in and limit in same cycle: DONE with timeout=0 (halt has priority).
REQ-025 abort in RESET/RUN/STEP -> IDLE next edge; abort has priority over halt_in, limit and step; abort in IDLE/DONE ignored.
REQ-026 DONE: core_rst=0, core_en=0, cycle_cnt and timeout held; start -> RESET (restart); start in RESET/RUN/STEP ignored.
REQ-027 start and abort in the same cycle in IDLE/DONE: start wins.
REQ-028 Outputs are registered or decoded from state only; no combinational path from any input to any output.

Reset
REQ-029 rst=1 at any edge, including mid-run: next state IDLE, core_rst=1, core_en=0, running=0, done=0, timeout=0, cycle_cnt=0, latched step_mode=0.
REQ-030 rst has priority over every other input.

Verification
REQ-031 rst 1 cycle, start, step_mode=0, halt_in at run cycle 10 -> core_rst high 2 cycles, core_en high 10 cycles, done=1, cycle_cnt=10, timeout=0.
REQ-032 MAX_CYCLES=20, start free-run, halt_in never -> done after 20 enabled cycles, cycle_cnt=20, timeout=1, core_en then 0.
REQ-033 step_mode=1, three single step pulses spaced 4 cycles -> exactly 3 one-cycle core_en pulses, cycle_cnt=3, running=1.
REQ-034 abort during RESET and again during RUN -> IDLE next edge, core_rst=1, core_en=0; halt_in and abort together -> IDLE, not DONE.
REQ-035 halt_in coincident with cycle_cnt reaching MAX_CYCLES -> done=1, timeout=0.
REQ-036 rst asserted mid-RUN with cycle_cnt=7 -> next cycle all outputs at reset values; following start runs normally.
